bus1_responder: RTL and testbench
=================================

# bus1_responder

Cache-side endpoint of the CPU↔L1 bus (A1/D1/C1).
- Captures the two-cycle command/address phase driven by the CPU and presents the decoded request to the cache core over a valid/ready handshake.
- Returns the core's result as C1_RESPONSE cycles, then hands bus ownership back to the CPU.
- Sits between the top-level bus wires and the cache core. It holds no cache state, only the protocol engine.

## Interface
Parameters:
- TAGSET_W, 15, width of tag+set field on A1 (first address cycle)
- OFFSET_W, 4, width of offset on A1 (second address cycle)
- DATA1_W, 16, D1 width
- CTR1_W, 3, C1 width
- TIMEOUT_CYCLES, 255, core response watchdog limit (used only with the watchdog macro)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  single clock, all state on rising edge
  - rst_n  in  1  asynchronous active-low reset
- Bus side:
  - a1  in  TAGSET_W  CPU address bus; offset occupies the low OFFSET_W bits in cycle 2
  - d1  inout  DATA1_W  data bus; driven only in RESP states
  - c1  inout  CTR1_W  command/response bus; driven only while owning
- Core request side:
  - req_valid  out  1  request presented
  - req_ready  in  1  core accepts request
  - req_cmd  out  CTR1_W  captured C1 command
  - req_tagset  out  TAGSET_W  captured tag+set
  - req_offset  out  OFFSET_W  captured offset
  - req_wdata  out  32  write data: {high half, low half}
- Core response side:
  - rsp_valid  in  1  core result ready (single-cycle pulse)
  - rsp_rdata  in  32  read result
- Status:
  - timeout_err  out  1  sticky watchdog flag

## Operation
Command codes: NOP 0, READ8 1, READ16 2, READ32 3, INVALIDATE_LINE 4, WRITE8 5, WRITE16 6, WRITE32 7, RESPONSE 7 (meaning is set by the direction of ownership).

States:
- **IDLE** (CPU owns the bus): c1/d1 are high-Z. A rising edge with c1≠NOP captures cmd, a1→tagset and d1→wdata[15:0].
  - INVALIDATE_LINE goes directly to TURN.
  - All other commands go to ADDR2.
- **ADDR2**: captures a1[OFFSET_W-1:0]→offset. For WRITE32 only, also captures d1→wdata[31:16]; otherwise wdata[31:16]=0. Goes to TURN.
- **TURN**: one turnaround cycle; responder takes ownership and drives c1=NOP, d1 high-Z. Goes to REQ.
- **REQ**: req_valid=1, all req_* fields stable. Leaves on req_valid&&req_ready and goes to WAIT.
- **WAIT**: c1=NOP. Goes to RESP1 on rsp_valid. rsp_valid is ignored in any other state; it is honoured no earlier than the cycle after the handshake.
- **RESP1**: c1=RESPONSE. d1 depends on the command:
  - READ8: {8'h0, rdata[7:0]}
  - READ16: rdata[15:0]
  - READ32: rdata[15:0]
  - all others: high-Z

  READ32 goes to RESP2; all other commands go to RELEASE.
- **RESP2**: c1=RESPONSE, d1=rdata[31:16]. Goes to RELEASE.
- **RELEASE**: c1 and d1 go high-Z; goes to IDLE. A new command is sampled no earlier than the following edge.

Other rules:
- rsp_rdata is latched on the rsp_valid edge; the core may change it afterwards.
- wdata for WRITE8/16 is masked to 8/16 bits respectively.

## Timing
- Reset values: req_valid=0, req_cmd=0, req_tagset=0, req_offset=0, req_wdata=0, timeout_err=0, c1/d1 high-Z, state IDLE.
- Reset asserted mid-transaction: immediate return to IDLE with the bus released. The pending request is dropped; no response is sent.
- Latency, command edge to first RESPONSE cycle: 4 + req wait + core latency cycles (3 for INVALIDATE_LINE). The minimum with ready=1 and rsp the cycle after the handshake is 5.
- Ownership: c1 is driven continuously from TURN through RESP2. There is never a cycle where both sides drive, because the CPU releases the bus after its second cycle.

## Configuration
- BUS1_RESP_TIMEOUT_EN defined:
  - An 8-bit+ counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without rsp_valid, timeout_err is set (sticky until reset) and the responder proceeds to RESP1 with rdata=0.
- Undefined: no counter; timeout_err is tied 0; WAIT is unbounded.

## Structure
- Shared package (alongside the existing constants): C1 command enum, state enum, bus width constants.
- Natural sub-module: bus1_tristate_drv, an enable-controlled driver pair for d1/c1.

## Test plan
- READ8, tagset 0x1234, offset 0x5, ready=1, rdata=0xDEADBEEF:
  - req_cmd=1, req_tagset=0x1234, req_offset=5.
  - One RESPONSE cycle with d1=0x00EF.
- READ32, rdata=0xCAFEBABE: two RESPONSE cycles, d1=0xBABE then 0xCAFE; bus high-Z on the next cycle.
- WRITE32, d1 0x5678 then 0x1234: req_wdata=0x12345678; one RESPONSE cycle with d1 high-Z.
- INVALIDATE_LINE, tagset 0x7FFF:
  - No ADDR2 cycle; req_offset=0; req_valid rises 2 edges after command.
  - One RESPONSE cycle.
- req_ready held low 10 cycles, then rst_n pulsed: req_valid=0, c1 high-Z immediately; the next READ16 completes normally.
- With BUS1_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=8, rsp_valid never asserted: timeout_err=1 after 8 WAIT cycles, RESPONSE with d1=0.

Source files
------------

// File: rtl/bus1_responder_pkg.sv
// Shared constants and types for the CPU<->L1 bus responder (A1/D1/C1).
package bus1_responder_pkg;

  localparam int TAGSET_W_DEF       = 15;
  localparam int OFFSET_W_DEF       = 4;
  localparam int DATA1_W_DEF        = 16;
  localparam int CTR1_W_DEF         = 3;
  localparam int WDATA_W            = 32;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    C1_NOP        = 3'd0,
    C1_READ8      = 3'd1,
    C1_READ16     = 3'd2,
    C1_READ32     = 3'd3,
    C1_INVALIDATE = 3'd4,
    C1_WRITE8     = 3'd5,
    C1_WRITE16    = 3'd6,
    C1_WRITE32    = 3'd7
  } c1_cmd_e;

  // Same code as WRITE32; the direction of bus ownership disambiguates it.
  localparam logic [2:0] C1_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR2,
    ST_TURN,
    ST_REQ,
    ST_WAIT,
    ST_RESP1,
    ST_RESP2,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/bus1_responder_if.sv
// Request/response channel between the bus responder and the cache core.
interface bus1_responder_if
  import bus1_responder_pkg::*;
#(
  parameter int TAGSET_W = TAGSET_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int CTR1_W   = CTR1_W_DEF
);
  // Request: a transfer happens on a rising edge where req_valid && req_ready;
  // req_* fields stay stable while req_valid waits for req_ready.
  // Response: rsp_valid is a single-cycle pulse that carries rsp_rdata; no ready.
  logic                req_valid;
  logic                req_ready;
  logic [CTR1_W-1:0]   req_cmd;
  logic [TAGSET_W-1:0] req_tagset;
  logic [OFFSET_W-1:0] req_offset;
  logic [WDATA_W-1:0]  req_wdata;
  logic                rsp_valid;
  logic [WDATA_W-1:0]  rsp_rdata;

  modport master (
    output req_valid, req_cmd, req_tagset, req_offset, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_cmd, req_tagset, req_offset, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/bus1_tristate_drv.sv
// Enable-controlled tri-state driver pair for the shared d1/c1 bus wires.
module bus1_tristate_drv #(
  parameter int DATA1_W = 16,
  parameter int CTR1_W  = 3
) (
  input  logic               d1_oe_i,
  input  logic [DATA1_W-1:0] d1_val_i,
  input  logic               c1_oe_i,
  input  logic [CTR1_W-1:0]  c1_val_i,
  inout  wire  [DATA1_W-1:0] d1_io,
  inout  wire  [CTR1_W-1:0]  c1_io
);

  assign d1_io = d1_oe_i ? d1_val_i : {DATA1_W{1'bz}};
  assign c1_io = c1_oe_i ? c1_val_i : {CTR1_W{1'bz}};

endmodule

// File: rtl/bus1_responder.sv
// Cache-side protocol engine of the CPU<->L1 bus. Optional core watchdog is
// enabled by defining BUS1_RESP_TIMEOUT_EN.
module bus1_responder
  import bus1_responder_pkg::*;
#(
  parameter int TAGSET_W       = TAGSET_W_DEF,
  parameter int OFFSET_W       = OFFSET_W_DEF,
  parameter int DATA1_W        = DATA1_W_DEF,
  parameter int CTR1_W         = CTR1_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TAGSET_W-1:0] a1,
  inout  wire  [DATA1_W-1:0]  d1,
  inout  wire  [CTR1_W-1:0]   c1,
  bus1_responder_if.master    core,
  output logic                timeout_err,
  output state_e              state_o
);

  localparam logic [CTR1_W-1:0] CMD_NOP   = CTR1_W'(C1_NOP);
  localparam logic [CTR1_W-1:0] CMD_RD8   = CTR1_W'(C1_READ8);
  localparam logic [CTR1_W-1:0] CMD_RD16  = CTR1_W'(C1_READ16);
  localparam logic [CTR1_W-1:0] CMD_RD32  = CTR1_W'(C1_READ32);
  localparam logic [CTR1_W-1:0] CMD_INV   = CTR1_W'(C1_INVALIDATE);
  localparam logic [CTR1_W-1:0] CMD_WR8   = CTR1_W'(C1_WRITE8);
  localparam logic [CTR1_W-1:0] CMD_WR32  = CTR1_W'(C1_WRITE32);
  localparam logic [CTR1_W-1:0] CMD_RESP  = CTR1_W'(C1_RESPONSE);

  state_e              state_q, state_d;
  logic [CTR1_W-1:0]   cmd_q, cmd_d;
  logic [TAGSET_W-1:0] tagset_q, tagset_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [WDATA_W-1:0]  wdata_q, wdata_d;
  logic [WDATA_W-1:0]  rdata_q, rdata_d;
  logic                wd_fire;

`ifdef BUS1_RESP_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  always_comb begin
    cnt_d   = '0;
    wd_fire = 1'b0;
    if (state_q == ST_WAIT && !core.rsp_valid) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) wd_fire = 1'b1;
      else                                     cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | wd_fire;
    end
  end

  assign timeout_err = err_q;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    tagset_d = tagset_q;
    offset_d = offset_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (c1 != CMD_NOP) begin
          cmd_d    = c1;
          tagset_d = a1;
          offset_d = '0;
          wdata_d  = '0;
          wdata_d[DATA1_W-1:0] = (c1 == CMD_WR8) ? DATA1_W'(d1[7:0]) : d1;
          state_d  = (c1 == CMD_INV) ? ST_TURN : ST_ADDR2;
        end
      end
      ST_ADDR2: begin
        offset_d = a1[OFFSET_W-1:0];
        if (cmd_q == CMD_WR32) wdata_d[2*DATA1_W-1:DATA1_W] = d1;
        state_d  = ST_TURN;
      end
      ST_TURN:    state_d = ST_REQ;
      ST_REQ:     if (core.req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (core.rsp_valid) begin
          rdata_d = core.rsp_rdata;
          state_d = ST_RESP1;
        end else if (wd_fire) begin
          rdata_d = '0;
          state_d = ST_RESP1;
        end
      end
      ST_RESP1:   state_d = (cmd_q == CMD_RD32) ? ST_RESP2 : ST_RELEASE;
      ST_RESP2:   state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      tagset_q <= '0;
      offset_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      tagset_q <= tagset_d;
      offset_q <= offset_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  logic               c1_oe, d1_oe, in_resp, is_read;
  logic [CTR1_W-1:0]  c1_val;
  logic [DATA1_W-1:0] d1_val;

  // The responder owns c1 from the turnaround cycle through the last response.
  always_comb begin
    in_resp = (state_q == ST_RESP1) || (state_q == ST_RESP2);
    is_read = (cmd_q == CMD_RD8) || (cmd_q == CMD_RD16) || (cmd_q == CMD_RD32);
    c1_oe   = (state_q == ST_TURN) || (state_q == ST_REQ) || (state_q == ST_WAIT) || in_resp;
    c1_val  = in_resp ? CMD_RESP : CMD_NOP;
    d1_oe   = (state_q == ST_RESP2) || (state_q == ST_RESP1 && is_read);
    if (state_q == ST_RESP2)  d1_val = rdata_q[2*DATA1_W-1:DATA1_W];
    else if (cmd_q == CMD_RD8) d1_val = DATA1_W'(rdata_q[7:0]);
    else                       d1_val = rdata_q[DATA1_W-1:0];
  end

  bus1_tristate_drv #(
    .DATA1_W (DATA1_W),
    .CTR1_W  (CTR1_W)
  ) u_drv (
    .d1_oe_i  (d1_oe),
    .d1_val_i (d1_val),
    .c1_oe_i  (c1_oe),
    .c1_val_i (c1_val),
    .d1_io    (d1),
    .c1_io    (c1)
  );

  assign core.req_valid  = (state_q == ST_REQ);
  assign core.req_cmd    = cmd_q;
  assign core.req_tagset = tagset_q;
  assign core.req_offset = offset_q;
  assign core.req_wdata  = wdata_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_bus1_responder.sv
// Directed bench for bus1_responder: CPU-side bus model with pulled-up d1/c1
// so a released bus reads all ones, and a hand-driven cache core.
module tb_bus1_responder;
  import bus1_responder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [14:0] a1;
  logic [15:0] cpu_d1;
  logic        cpu_d1_en;
  logic [2:0]  cpu_c1;
  logic        cpu_c1_en;
  wire  [15:0] d1;
  wire  [2:0]  c1;
  logic        timeout_err;
  state_e      dbg_state;
  int          checks;
  int          errors;

  assign d1 = cpu_d1_en ? cpu_d1 : 16'hzzzz;
  assign c1 = cpu_c1_en ? cpu_c1 : 3'bzzz;
  pullup pu_d1 (d1);
  pullup pu_c1 (c1);

  bus1_responder_if #(.TAGSET_W(15), .OFFSET_W(4), .CTR1_W(3)) core_if ();

  bus1_responder #(
    .TAGSET_W       (15),
    .OFFSET_W       (4),
    .DATA1_W        (16),
    .CTR1_W         (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a1          (a1),
    .d1          (d1),
    .c1          (c1),
    .core        (core_if.master),
    .timeout_err (timeout_err),
    .state_o     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the responder idle; returns with it in TURN.
  task automatic cpu_send(input logic [2:0] cmd, input logic [14:0] ts, input logic [3:0] off,
                          input logic [15:0] dlo, input logic [15:0] dhi, input bit has_addr2);
    cpu_c1    = cmd;
    cpu_c1_en = 1'b1;
    a1        = ts;
    cpu_d1    = dlo;
    cpu_d1_en = 1'b1;
    next_cycle();
    if (has_addr2) begin
      a1     = {11'h0, off};
      cpu_d1 = dhi;
      next_cycle();
    end
    cpu_c1_en = 1'b0;
    cpu_d1_en = 1'b0;
    cpu_c1    = 3'd0;
    a1        = '0;
  endtask

  task automatic cpu_retake();
    cpu_c1    = 3'd0;
    cpu_c1_en = 1'b1;
  endtask

  // From REQ with ready high: respond next cycle and return the bus to the CPU.
  task automatic core_finish(input logic [31:0] rd);
    next_cycle();
    core_if.rsp_valid = 1'b1;
    core_if.rsp_rdata = rd;
    next_cycle();
    core_if.rsp_valid = 1'b0;
    core_if.rsp_rdata = '0;
    next_cycle();
    next_cycle();
    cpu_retake();
  endtask

  // Directed sequence
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a1 = '0;
    cpu_c1 = 3'd0;
    cpu_c1_en = 1'b0;
    cpu_d1 = '0;
    cpu_d1_en = 1'b0;
    core_if.req_ready = 1'b0;
    core_if.rsp_valid = 1'b0;
    core_if.rsp_rdata = '0;
    repeat (2) next_cycle();
    settle();
    chk("rst_req_valid", 32'(core_if.req_valid), 32'd0);
    chk("rst_req_cmd", 32'(core_if.req_cmd), 32'd0);
    chk("rst_req_tagset", 32'(core_if.req_tagset), 32'd0);
    chk("rst_req_offset", 32'(core_if.req_offset), 32'd0);
    chk("rst_req_wdata", core_if.req_wdata, 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_c1_z", 32'(c1), 32'h7);
    chk("rst_d1_z", 32'(d1), 32'hFFFF);
    next_cycle();
    cpu_retake();
    rst_n = 1'b1;
    next_cycle();

    // READ8 with an early rsp_valid in REQ that must be ignored
    core_if.req_ready = 1'b1;
    cpu_send(3'(C1_READ8), 15'h1234, 4'h5, 16'h0000, 16'h0000, 1'b1);
    settle();
    chk("r8_turn_state", 32'(dbg_state), 32'(ST_TURN));
    chk("r8_turn_c1", 32'(c1), 32'h0);
    chk("r8_turn_d1_z", 32'(d1), 32'hFFFF);
    next_cycle();
    core_if.rsp_valid = 1'b1;
    core_if.rsp_rdata = 32'h1111_1111;
    settle();
    chk("r8_req_valid", 32'(core_if.req_valid), 32'd1);
    chk("r8_req_cmd", 32'(core_if.req_cmd), 32'd1);
    chk("r8_req_tagset", 32'(core_if.req_tagset), 32'h1234);
    chk("r8_req_offset", 32'(core_if.req_offset), 32'h5);
    next_cycle();
    core_if.rsp_rdata = 32'hDEAD_BEEF;
    settle();
    chk("r8_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    chk("r8_wait_valid", 32'(core_if.req_valid), 32'd0);
    chk("r8_wait_c1", 32'(c1), 32'h0);
    next_cycle();
    core_if.rsp_valid = 1'b0;
    core_if.rsp_rdata = '0;
    settle();
    chk("r8_resp1_state", 32'(dbg_state), 32'(ST_RESP1));
    chk("r8_resp1_c1", 32'(c1), 32'h7);
    chk("r8_resp1_d1", 32'(d1), 32'h00EF);
    next_cycle();
    settle();
    chk("r8_release_state", 32'(dbg_state), 32'(ST_RELEASE));
    chk("r8_release_d1_z", 32'(d1), 32'hFFFF);
    next_cycle();
    cpu_retake();
    settle();
    chk("r8_idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // READ32 with one cycle of core latency beyond the minimum
    next_cycle();
    cpu_send(3'(C1_READ32), 15'h0ABC, 4'hF, 16'h0000, 16'h0000, 1'b1);
    next_cycle();
    settle();
    chk("r32_req_cmd", 32'(core_if.req_cmd), 32'd3);
    chk("r32_req_offset", 32'(core_if.req_offset), 32'hF);
    next_cycle();
    next_cycle();
    core_if.rsp_valid = 1'b1;
    core_if.rsp_rdata = 32'hCAFE_BABE;
    settle();
    chk("r32_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    next_cycle();
    core_if.rsp_valid = 1'b0;
    core_if.rsp_rdata = '0;
    settle();
    chk("r32_resp1_c1", 32'(c1), 32'h7);
    chk("r32_resp1_d1", 32'(d1), 32'hBABE);
    next_cycle();
    settle();
    chk("r32_resp2_state", 32'(dbg_state), 32'(ST_RESP2));
    chk("r32_resp2_c1", 32'(c1), 32'h7);
    chk("r32_resp2_d1", 32'(d1), 32'hCAFE);
    next_cycle();
    settle();
    chk("r32_release_state", 32'(dbg_state), 32'(ST_RELEASE));
    chk("r32_release_d1_z", 32'(d1), 32'hFFFF);
    chk("r32_release_c1_z", 32'(c1), 32'h7);
    next_cycle();
    cpu_retake();
    settle();
    chk("r32_idle_c1", 32'(c1), 32'h0);

    // WRITE32: both data halves captured, response carries no data
    next_cycle();
    cpu_send(3'(C1_WRITE32), 15'h0042, 4'h3, 16'h5678, 16'h1234, 1'b1);
    next_cycle();
    settle();
    chk("w32_req_wdata", core_if.req_wdata, 32'h1234_5678);
    chk("w32_req_cmd", 32'(core_if.req_cmd), 32'd7);
    next_cycle();
    core_if.rsp_valid = 1'b1;
    core_if.rsp_rdata = 32'h5A5A_A5A5;
    next_cycle();
    core_if.rsp_valid = 1'b0;
    settle();
    chk("w32_resp1_state", 32'(dbg_state), 32'(ST_RESP1));
    chk("w32_resp1_c1", 32'(c1), 32'h7);
    chk("w32_resp1_d1_z", 32'(d1), 32'hFFFF);
    next_cycle();
    settle();
    chk("w32_release_state", 32'(dbg_state), 32'(ST_RELEASE));
    next_cycle();
    cpu_retake();

    // WRITE8 / WRITE16 masking
    next_cycle();
    cpu_send(3'(C1_WRITE8), 15'h0011, 4'h9, 16'hABCD, 16'h9999, 1'b1);
    next_cycle();
    settle();
    chk("w8_req_wdata", core_if.req_wdata, 32'h0000_00CD);
    chk("w8_req_offset", 32'(core_if.req_offset), 32'h9);
    core_finish(32'h0);
    next_cycle();
    cpu_send(3'(C1_WRITE16), 15'h2222, 4'h1, 16'hBEEF, 16'h7777, 1'b1);
    next_cycle();
    settle();
    chk("w16_req_wdata", core_if.req_wdata, 32'h0000_BEEF);
    core_finish(32'h0);

    // INVALIDATE_LINE: no ADDR2 cycle, offset cleared
    next_cycle();
    cpu_send(3'(C1_INVALIDATE), 15'h7FFF, 4'h0, 16'h0000, 16'h0000, 1'b0);
    settle();
    chk("inv_turn_state", 32'(dbg_state), 32'(ST_TURN));
    chk("inv_turn_valid", 32'(core_if.req_valid), 32'd0);
    next_cycle();
    settle();
    chk("inv_req_valid", 32'(core_if.req_valid), 32'd1);
    chk("inv_req_cmd", 32'(core_if.req_cmd), 32'd4);
    chk("inv_req_tagset", 32'(core_if.req_tagset), 32'h7FFF);
    chk("inv_req_offset", 32'(core_if.req_offset), 32'h0);
    chk("inv_req_wdata", core_if.req_wdata, 32'h0);
    next_cycle();
    core_if.rsp_valid = 1'b1;
    core_if.rsp_rdata = 32'h0F0F_0F0F;
    next_cycle();
    core_if.rsp_valid = 1'b0;
    settle();
    chk("inv_resp1_c1", 32'(c1), 32'h7);
    chk("inv_resp1_d1_z", 32'(d1), 32'hFFFF);
    next_cycle();
    settle();
    chk("inv_release_state", 32'(dbg_state), 32'(ST_RELEASE));
    next_cycle();
    cpu_retake();

    // Stalled request, then asynchronous reset mid-transaction
    core_if.req_ready = 1'b0;
    next_cycle();
    cpu_send(3'(C1_READ16), 15'h0100, 4'h2, 16'h0000, 16'h0000, 1'b1);
    repeat (11) next_cycle();
    settle();
    chk("stall_state", 32'(dbg_state), 32'(ST_REQ));
    chk("stall_req_valid", 32'(core_if.req_valid), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    #2;
    chk("arst_req_valid", 32'(core_if.req_valid), 32'd0);
    chk("arst_c1_z", 32'(c1), 32'h7);
    chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("arst_req_cmd", 32'(core_if.req_cmd), 32'd0);
    cpu_retake();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // READ16 after reset completes normally
    core_if.req_ready = 1'b1;
    cpu_send(3'(C1_READ16), 15'h0200, 4'h6, 16'h0000, 16'h0000, 1'b1);
    next_cycle();
    settle();
    chk("r16_req_tagset", 32'(core_if.req_tagset), 32'h0200);
    chk("r16_req_offset", 32'(core_if.req_offset), 32'h6);
    next_cycle();
    core_if.rsp_valid = 1'b1;
    core_if.rsp_rdata = 32'h8765_4321;
    next_cycle();
    core_if.rsp_valid = 1'b0;
    core_if.rsp_rdata = '0;
    settle();
    chk("r16_resp1_c1", 32'(c1), 32'h7);
    chk("r16_resp1_d1", 32'(d1), 32'h4321);
    next_cycle();
    settle();
    chk("r16_release_state", 32'(dbg_state), 32'(ST_RELEASE));
    chk("r16_timeout", 32'(timeout_err), 32'd0);
    next_cycle();
    cpu_retake();

`ifdef BUS1_RESP_TIMEOUT_EN
    // Core never answers: watchdog fires after 8 WAIT cycles
    next_cycle();
    cpu_send(3'(C1_READ16), 15'h0333, 4'h7, 16'h0000, 16'h0000, 1'b1);
    next_cycle();
    next_cycle();
    repeat (7) next_cycle();
    settle();
    chk("wd_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    chk("wd_err_before", 32'(timeout_err), 32'd0);
    next_cycle();
    settle();
    chk("wd_resp1_state", 32'(dbg_state), 32'(ST_RESP1));
    chk("wd_err_after", 32'(timeout_err), 32'd1);
    chk("wd_resp1_d1", 32'(d1), 32'h0000);
    next_cycle();
    next_cycle();
    cpu_retake();
    settle();
    chk("wd_err_sticky", 32'(timeout_err), 32'd1);
`endif

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
